// File: rtl/key_debouncer.sv
// key_debouncer: 2-flop synchronizer, debounce filter and hold/repeat
// event generator for a bank of active-low pushbuttons.
//
// Ports:
//   CLOCK_50    in   1       system clock, rising edge
//   RESET       in   1       asynchronous, active-high reset
//   KEY         in   N_KEYS  raw pushbuttons, active-low, asynchronous
//   key_level   out  N_KEYS  debounced state, 1 = pressed
//   key_press   out  N_KEYS  1-cycle pulse on an accepted press
//   key_release out  N_KEYS  1-cycle pulse on an accepted release
//   key_hold    out  N_KEYS  1 while pressed for >= HOLD_CYCLES
//   key_repeat  out  N_KEYS  pulse at hold entry, then every REPEAT_CYCLES
//
// DEBOUNCE_CYCLES, HOLD_CYCLES and REPEAT_CYCLES must each be >= 2.

module key_debouncer #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_hold,
    output logic [N_KEYS-1:0] key_repeat
);

    localparam int MAX_DH  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ?
                             DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYC = (MAX_DH > REPEAT_CYCLES) ?
                             MAX_DH : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_PRESSED,
        S_HELD,
        S_RELEASE_WAIT
    } state_e;

    // Synchronizer resets to the released level so that reset itself
    // never looks like a press to the filter.
    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;
    logic [N_KEYS-1:0] pressed_s;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= KEY;
            sync2_q <= sync1_q;
        end
    end

    assign pressed_s = ~sync2_q;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        state_e           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             held_q;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             hold_q;
        logic             repeat_q;
        logic             s;
        logic             deb_done;
        logic             hold_done;
        logic             rep_done;

        assign s         = pressed_s[k];
        assign cnt_d     = cnt_q + CNT_ONE;
        assign deb_done  = (cnt_q == DEB_LAST);
        assign hold_done = (cnt_q == HOLD_LAST);
        assign rep_done  = (cnt_q == REP_LAST);

        // One counter serves debounce, hold and repeat timing; every
        // state transition restarts it from zero.
        always_ff @(posedge CLOCK_50 or posedge RESET) begin
            if (RESET) begin
                state_q   <= S_IDLE;
                cnt_q     <= '0;
                held_q    <= 1'b0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                hold_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
                unique case (state_q)
                    S_IDLE: begin
                        if (s) begin
                            state_q <= S_PRESS_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    S_PRESS_WAIT: begin
                        if (!s) begin
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                        end else if (deb_done) begin
                            state_q <= S_PRESSED;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    S_PRESSED: begin
                        if (!s) begin
                            state_q <= S_RELEASE_WAIT;
                            cnt_q   <= '0;
                        end else if (hold_done) begin
                            state_q  <= S_HELD;
                            cnt_q    <= '0;
                            held_q   <= 1'b1;
                            hold_q   <= 1'b1;
                            repeat_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    S_HELD: begin
                        if (!s) begin
                            state_q <= S_RELEASE_WAIT;
                            cnt_q   <= '0;
                        end else if (rep_done) begin
                            cnt_q    <= '0;
                            repeat_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    S_RELEASE_WAIT: begin
                        // A bounce back to pressed resumes the phase the
                        // key was in, with its timer restarted.
                        if (s) begin
                            state_q <= held_q ? S_HELD : S_PRESSED;
                            cnt_q   <= '0;
                        end else if (deb_done) begin
                            state_q   <= S_IDLE;
                            cnt_q     <= '0;
                            level_q   <= 1'b0;
                            hold_q    <= 1'b0;
                            held_q    <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign key_level[k]   = level_q;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;
        assign key_hold[k]    = hold_q;
        assign key_repeat[k]  = repeat_q;
    end

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: scenario tasks plus randomized traffic, checked
// against a run-length / timestamp model of the debouncer behaviour.

module tb_key_debouncer;

    localparam int NK  = 4;
    localparam int DB  = 4;
    localparam int HC  = 20;
    localparam int RC  = 8;
    localparam int LAT = DB + 3;

    logic          CLOCK_50 = 1'b0;
    logic          RESET    = 1'b0;
    logic [NK-1:0] KEY      = '1;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_hold;
    logic [NK-1:0] key_repeat;

    key_debouncer #(
        .N_KEYS(NK),
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES(HC),
        .REPEAT_CYCLES(RC)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .RESET(RESET),
        .KEY(KEY),
        .key_level(key_level),
        .key_press(key_press),
        .key_release(key_release),
        .key_hold(key_hold),
        .key_repeat(key_repeat)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int p0    = 0;
    logic [NK-1:0] kv = '1;

    // Reference model: a level flips once the synchronized input has
    // disagreed with it on DB+1 consecutive edges; hold/repeat fire on
    // edge-count distances from the latest press or bounce return.
    logic [NK-1:0] m_lvl = '0, m_press = '0, m_rel = '0;
    logic [NK-1:0] m_hold = '0, m_rep = '0;
    logic [NK-1:0] m_h0 = '1, m_h1 = '1;
    int m_run[NK];
    int m_anchor[NK];
    int m_edge = 0;

    always @(posedge CLOCK_50 or posedge RESET) begin : model
        logic [NK-1:0] lv, hd, pr, rl, rp;
        int rn[NK];
        int an[NK];
        int en;
        logic s;
        if (RESET) begin
            m_lvl <= '0; m_press <= '0; m_rel <= '0;
            m_hold <= '0; m_rep <= '0;
            m_h0 <= '1; m_h1 <= '1; m_edge <= 0;
            for (int i = 0; i < NK; i++) begin
                m_run[i] <= 0;
                m_anchor[i] <= 0;
            end
        end else begin
            en = m_edge + 1;
            lv = m_lvl; hd = m_hold;
            pr = '0; rl = '0; rp = '0;
            rn = m_run; an = m_anchor;
            for (int i = 0; i < NK; i++) begin
                s = ~m_h1[i];
                if (s != lv[i]) begin
                    rn[i] = rn[i] + 1;
                    if (rn[i] == DB + 1) begin
                        rn[i] = 0;
                        lv[i] = s;
                        if (s) begin
                            pr[i] = 1'b1;
                            an[i] = en;
                        end else begin
                            rl[i] = 1'b1;
                            hd[i] = 1'b0;
                        end
                    end
                end else begin
                    if (lv[i]) begin
                        if (rn[i] > 0) an[i] = en;
                        else if (!hd[i] && en - an[i] == HC) begin
                            hd[i] = 1'b1; rp[i] = 1'b1; an[i] = en;
                        end else if (hd[i] && en - an[i] == RC) begin
                            rp[i] = 1'b1; an[i] = en;
                        end
                    end
                    rn[i] = 0;
                end
            end
            m_edge <= en;
            m_lvl <= lv; m_hold <= hd;
            m_press <= pr; m_rel <= rl; m_rep <= rp;
            m_run <= rn; m_anchor <= an;
            m_h1 <= m_h0; m_h0 <= KEY;
        end
    end

    logic [5*NK-1:0] got_v, exp_v;
    assign got_v = {key_level, key_press, key_release, key_hold, key_repeat};
    assign exp_v = {m_lvl, m_press, m_rel, m_hold, m_rep};

    // Drive only: present kv, let one rising edge sample it, park on
    // the following falling edge.
    task automatic tick();
        KEY = kv;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        cyc++;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        #1 RESET = 1'b1;
        kv = '1;
        KEY = kv;
        repeat (3) @(negedge CLOCK_50);
        total++;
        if (got_v !== '0) begin
            bad++;
            $display("FAIL reset_state got=%h want=0", got_v);
        end
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%h want=%h",
                         cyc, got_v, exp_v);
            end
        end
    endtask

    task automatic test_clean_press();
        int pe = 0;
        int np = 0;
        kv[0] = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL clean_press cyc=%0d got=%h want=%h",
                         cyc, got_v, exp_v);
            end
            if (key_press[0]) begin
                np++;
                if (pe == 0) begin
                    pe = e;
                    p0 = cyc;
                end
            end
        end
        total++;
        if (pe != LAT) begin
            bad++;
            $display("FAIL clean_press_edge got=%0d want=%0d", pe, LAT);
        end
        total++;
        if (np != 1) begin
            bad++;
            $display("FAIL clean_press_count got=%0d want=1", np);
        end
        total++;
        if (key_level !== 4'b0001) begin
            bad++;
            $display("FAIL clean_press_level got=%b want=0001", key_level);
        end
    endtask

    task automatic test_hold_repeat();
        int hold_off = -1;
        int reps[$];
        int want[$];
        for (int o = HC; o < 60; o += RC) want.push_back(o);
        while (cyc < p0 + 59) begin
            tick();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL hold_repeat cyc=%0d got=%h want=%h",
                         cyc, got_v, exp_v);
            end
            if (key_hold[0] && hold_off < 0) hold_off = cyc - p0;
            if (key_repeat[0]) reps.push_back(cyc - p0);
        end
        total++;
        if (hold_off != HC) begin
            bad++;
            $display("FAIL hold_entry got=%0d want=%0d", hold_off, HC);
        end
        total++;
        if (reps.size() != want.size()) begin
            bad++;
            $display("FAIL repeat_count got=%0d want=%0d",
                     reps.size(), want.size());
        end else begin
            for (int j = 0; j < want.size(); j++) begin
                total++;
                if (reps[j] != want[j]) begin
                    bad++;
                    $display("FAIL repeat_offset j=%0d got=%0d want=%0d",
                             j, reps[j], want[j]);
                end
            end
        end
        total++;
        if (key_hold[0] !== 1'b1) begin
            bad++;
            $display("FAIL hold_stays got=%b want=1", key_hold[0]);
        end
    endtask

    task automatic test_release_bounce();
        logic [3:0] pat;
        int re = 0;
        int nr = 0;
        logic hold_pre = 1'b0;
        pat = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            kv[0] = pat[i];
            tick();
            total++;
            if (got_v !== exp_v || key_hold[0] !== 1'b1) begin
                bad++;
                $display("FAIL release_bounce cyc=%0d got=%h want=%h",
                         cyc, got_v, exp_v);
            end
        end
        kv[0] = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL release_wait cyc=%0d got=%h want=%h",
                         cyc, got_v, exp_v);
            end
            if (e == LAT - 1) hold_pre = key_hold[0];
            if (key_release[0]) begin
                nr++;
                if (re == 0) re = e;
                total++;
                if (key_hold[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL release_hold_clear got=%b want=0",
                             key_hold[0]);
                end
            end
        end
        total++;
        if (re != LAT || nr != 1) begin
            bad++;
            $display("FAIL release_edge got=%0d/%0d want=%0d/1",
                     re, nr, LAT);
        end
        total++;
        if (hold_pre !== 1'b1) begin
            bad++;
            $display("FAIL release_hold_pre got=%b want=1", hold_pre);
        end
    endtask

    task automatic test_glitch();
        int ev = 0;
        for (int e = 0; e < 14; e++) begin
            kv[1] = (e < 3) ? 1'b0 : 1'b1;
            tick();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL glitch cyc=%0d got=%h want=%h",
                         cyc, got_v, exp_v);
            end
            if (key_press[1] || key_level[1] || key_release[1]) ev++;
        end
        total++;
        if (ev != 0) begin
            bad++;
            $display("FAIL glitch_events got=%0d want=0", ev);
        end
    endtask

    task automatic test_bouncy();
        int pe = 0;
        int np = 0;
        for (int i = 0; i < 10; i++) begin
            kv[2] = (i % 2 == 1);
            tick();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL bouncy cyc=%0d got=%h want=%h",
                         cyc, got_v, exp_v);
            end
            if (key_press[2]) np++;
        end
        kv[2] = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL bouncy_settle cyc=%0d got=%h want=%h",
                         cyc, got_v, exp_v);
            end
            if (key_press[2]) begin
                np++;
                if (pe == 0) pe = e;
            end
        end
        total++;
        if (pe != LAT || np != 1) begin
            bad++;
            $display("FAIL bouncy_press got=%0d/%0d want=%0d/1", pe, np, LAT);
        end
    endtask

    task automatic test_reset_mid();
        int pe = 0;
        int guard = 0;
        kv[3] = 1'b0;
        while (key_level[3] !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        total++;
        if (key_level[3] !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_setup got=%b want=1", key_level[3]);
        end
        #2 RESET = 1'b1;
        #1;
        total++;
        if (got_v !== '0) begin
            bad++;
            $display("FAIL reset_mid_clear got=%h want=0", got_v);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (got_v !== '0) begin
                bad++;
                $display("FAIL reset_mid_hold cyc=%0d got=%h want=0",
                         cyc, got_v);
            end
        end
        RESET = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL reset_mid_after cyc=%0d got=%h want=%h",
                         cyc, got_v, exp_v);
            end
            if (key_press[3] && pe == 0) pe = e;
        end
        total++;
        if (pe != LAT) begin
            bad++;
            $display("FAIL reset_mid_press got=%0d want=%0d", pe, LAT);
        end
    endtask

    task automatic test_random();
        int left[NK];
        int overlap = 0;
        int errs = 0;
        for (int i = 0; i < NK; i++) left[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NK; i++) begin
                if (left[i] == 0) begin
                    kv[i] = $urandom_range(1, 0) == 1;
                    left[i] = ($urandom_range(3, 0) == 0) ?
                              $urandom_range(5, 1) :
                              $urandom_range(60, 6);
                end
                left[i]--;
            end
            tick();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL random cyc=%0d got=%h want=%h",
                             cyc, got_v, exp_v);
            end
            if ((key_press & key_release) != '0) overlap++;
        end
        total++;
        if (overlap != 0) begin
            bad++;
            $display("FAIL press_release_overlap got=%0d want=0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_hold_repeat();
        test_release_bounce();
        test_glitch();
        test_bouncy();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
